// File: rtl/exp_scale_seq.sv
// Sequential e^x approximation for unsigned Q4.8 operands: a per-integer scale
// from a small table multiplied by (1+f) with a 9-step shift-and-add loop.
module exp_scale_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q;
  logic [11:0] scale_q;
  logic [11:0] scale_d;
  logic [8:0]  mult_q;
  logic [20:0] acc_q;
  logic [20:0] acc_d;
  logic [20:0] addend;
  logic [3:0]  cnt_q;
  logic        out_valid_q;
  logic [11:0] out_data_q;

  // Scale is e^i in Q4.8, clamped to 2047 once e^i no longer fits usefully.
  always_comb begin
    scale_d = 12'd2047;
    case (in_data[11:8])
      4'd0:    scale_d = 12'd256;
      4'd1:    scale_d = 12'd696;
      4'd2:    scale_d = 12'd1892;
      default: scale_d = 12'd2047;
    endcase
  end

  always_comb begin
    addend = 21'd0;
    if (mult_q[cnt_q]) begin
      addend = {9'd0, scale_q} << cnt_q;
    end
    acc_d = acc_q + addend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scale_q     <= 12'd0;
      mult_q      <= 9'd0;
      acc_q       <= 21'd0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 12'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            scale_q <= scale_d;
            mult_q  <= {1'b1, in_data[7:0]};
            acc_q   <= 21'd0;
            cnt_q   <= 4'd0;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 4'd1;
          // The last step's add must land in the result, so take it from acc_d.
          if (cnt_q == 4'd8) begin
            out_data_q  <= acc_d[19:8];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_exp_scale_seq.sv
// Directed bench for exp_scale_seq: reset state, table/fraction vectors,
// latency, backpressure, mid-operation reset and back-to-back throughput.
module tb_exp_scale_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  exp_scale_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic applyStimulus(input logic [11:0] data, input bit hold,
                               output int acceptEdge, output bit accepted);
    accepted   = 1'b0;
    acceptEdge = 0;
    in_data    = data;
    in_valid   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        acceptEdge = edgeCount + 1;
        accepted   = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitResult(output int validEdge, output bit seen, output int busyCnt);
    seen      = 1'b0;
    validEdge = 0;
    busyCnt   = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        seen      = 1'b1;
        validEdge = edgeCount;
        break;
      end
      if (busy) busyCnt++;
      @(negedge clk);
    end
  endtask

  // One operation with out_ready already high; the accepting edge is edge 1
  // of the 10, so out_valid is seen 9 edges after it.
  task automatic runOp(input logic [11:0] data, input logic [11:0] expected,
                       input string tag);
    int a, v, b;
    bit acc, seen;
    applyStimulus(data, 1'b0, a, acc);
    checkOutput({tag, "_accept"}, 32'(acc), 32'd1);
    waitResult(v, seen, b);
    checkOutput({tag, "_valid"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(v - a), 32'd9);
    checkOutput({tag, "_data"}, 32'(out_data), 32'(expected));
    @(negedge clk);
    checkOutput({tag, "_release"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_hold"}, 32'(out_data), 32'(expected));
  endtask

  logic [11:0] b2bIn  [8] = '{12'h001, 12'h0FF, 12'h101, 12'h140,
                              12'h200, 12'h2FF, 12'h310, 12'hF80};
  logic [11:0] b2bOut [8] = '{12'h101, 12'h1FF, 12'h2BA, 12'h366,
                              12'h764, 12'hEC0, 12'h87E, 12'hBFE};

  initial begin
    int a, v, b, prevA, busyCycles;
    bit acc, seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 12'h000;
    out_ready = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero operand: latency, busy span and release.
    out_ready = 1'b1;
    applyStimulus(12'h000, 1'b0, a, acc);
    checkOutput("zero_accept", 32'(acc), 32'd1);
    waitResult(v, seen, b);
    checkOutput("zero_valid", 32'(seen), 32'd1);
    checkOutput("zero_latency", 32'(v - a), 32'd9);
    checkOutput("zero_data", 32'(out_data), 32'h100);
    busyCycles = b + (busy ? 1 : 0);
    checkOutput("zero_busy_cycles", 32'(busyCycles), 32'd10);
    @(negedge clk);
    checkOutput("zero_release", 32'(out_valid), 32'd0);
    checkOutput("zero_idle_busy", 32'(busy), 32'd0);
    checkOutput("zero_in_ready", 32'(in_ready), 32'd1);

    runOp(12'h100, 12'h2B8, "x100");
    runOp(12'h180, 12'h414, "x180");
    runOp(12'h280, 12'hB16, "x280");
    runOp(12'h3FF, 12'hFF6, "x3FF");
    runOp(12'hA00, 12'h7FF, "xA00");

    // Backpressure with a second operand offered while the result waits.
    out_ready = 1'b0;
    applyStimulus(12'h180, 1'b0, a, acc);
    waitResult(v, seen, b);
    checkOutput("bp_valid", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_stall_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_stall_data", 32'(out_data), 32'h414);
      checkOutput("bp_stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = (i == 1 || i == 2);
      in_data  = 12'h3FF;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    checkOutput("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", 32'(out_valid), 32'd0);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_hold_data", 32'(out_data), 32'h414);
    @(negedge clk);
    checkOutput("bp_not_taken", 32'(busy), 32'd0);

    // Reset while MUL is at cnt=4, then an immediate new operand.
    applyStimulus(12'h280, 1'b0, a, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_out_data", 32'(out_data), 32'd0);
    checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("mrst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    applyStimulus(12'h101, 1'b0, a, acc);
    checkOutput("mrst_accept", 32'(acc), 32'd1);
    waitResult(v, seen, b);
    checkOutput("mrst_latency", 32'(v - a), 32'd9);
    checkOutput("mrst_data", 32'(out_data), 32'h2BA);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    prevA     = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(b2bIn[k], 1'b1, a, acc);
      checkOutput("b2b_accept", 32'(acc), 32'd1);
      if (k > 0) checkOutput("b2b_interval", 32'(a - prevA), 32'd11);
      prevA = a;
      waitResult(v, seen, b);
      checkOutput("b2b_valid", 32'(seen), 32'd1);
      checkOutput("b2b_data", 32'(out_data), 32'(b2bOut[k]));
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
